// File: rtl/xm_stage_buf.sv
// EX->MEM boundary: selects address/value from the execute result sources, forwards
// write-back data into store data, and registers the op behind a 2-entry skid buffer.
module xm_stage_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5,
   parameter int NSRC   = 2,
   localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     x_valid,
   output logic                     x_ready,
   input  logic [NSRC*ADDR_W-1:0]   x_addr,
   input  logic [NSRC*DATA_W-1:0]   x_val,
   input  logic [SEL_W-1:0]         x_addr_sel,
   input  logic [SEL_W-1:0]         x_val_sel,
   input  logic                     x_read,
   input  logic                     x_write,
   input  logic [REG_W-1:0]         x_dst,
   input  logic [REG_W-1:0]         x_rt,
   input  logic                     wb_valid,
   input  logic [REG_W-1:0]         wb_dst,
   input  logic [DATA_W-1:0]        wb_val,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_read,
   output logic                     m_write,
   output logic [ADDR_W-1:0]        m_addr,
   output logic [DATA_W-1:0]        m_val,
   output logic [REG_W-1:0]         m_dst
);

   typedef struct packed {
      logic              vld;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;
      logic [REG_W-1:0]  dst;
      logic [REG_W-1:0]  rt;
   } entry_t;

   entry_t r_a, r_b;
   entry_t w_a_fwd, w_b_fwd, w_new, w_a_nxt, w_b_nxt;
   logic   w_accept, w_drain;

   // Out-of-range selects fall back to source 0.
   function automatic logic [ADDR_W-1:0] sel_addr(input logic [NSRC*ADDR_W-1:0] v,
                                                   input logic [SEL_W-1:0] s);
      logic [ADDR_W-1:0] r;
      r = v[ADDR_W-1:0];
      for (int i = 0; i < NSRC; i++)
         if (s == SEL_W'(i)) r = v[i*ADDR_W +: ADDR_W];
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] sel_val(input logic [NSRC*DATA_W-1:0] v,
                                                  input logic [SEL_W-1:0] s);
      logic [DATA_W-1:0] r;
      r = v[DATA_W-1:0];
      for (int i = 0; i < NSRC; i++)
         if (s == SEL_W'(i)) r = v[i*DATA_W +: DATA_W];
      return r;
   endfunction

   function automatic logic fwd_hit(input logic wr, input logic [REG_W-1:0] rt,
                                    input logic wv, input logic [REG_W-1:0] wd);
      return wr && wv && (wd == rt) && (rt != '0);
   endfunction

   function automatic entry_t fwd_hold(input entry_t e, input logic wv,
                                       input logic [REG_W-1:0] wd,
                                       input logic [DATA_W-1:0] wval);
      entry_t r;
      r = e;
      if (e.vld && fwd_hit(e.wr, e.rt, wv, wd)) r.val = wval;
      return r;
   endfunction

   always_comb begin
      w_accept = x_valid && !r_b.vld;
      w_drain  = r_a.vld && m_ready;

      w_a_fwd = fwd_hold(r_a, wb_valid, wb_dst, wb_val);
      w_b_fwd = fwd_hold(r_b, wb_valid, wb_dst, wb_val);

      w_new      = '0;
      w_new.vld  = 1'b1;
      w_new.rd   = x_read;
      w_new.wr   = x_write;
      w_new.addr = sel_addr(x_addr, x_addr_sel);
      w_new.val  = fwd_hit(x_write, x_rt, wb_valid, wb_dst) ? wb_val
                                                            : sel_val(x_val, x_val_sel);
      w_new.dst  = x_dst;
      w_new.rt   = x_rt;

      w_a_nxt = w_a_fwd;
      w_b_nxt = w_b_fwd;
      // A drain coinciding with flush has already been taken by memory, so just kill both.
      if (flush) begin
         w_a_nxt.vld = 1'b0;
         w_b_nxt.vld = 1'b0;
      end else if (!r_a.vld) begin
         if (w_accept) w_a_nxt = w_new;
      end else if (w_drain) begin
         if (w_accept && r_b.vld) begin
            w_a_nxt = w_b_fwd;
            w_b_nxt = w_new;
         end else if (w_accept) begin
            w_a_nxt = w_new;
         end else begin
            w_a_nxt     = w_b_fwd;
            w_b_nxt.vld = 1'b0;
         end
      end else if (w_accept) begin
         w_b_nxt = w_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= w_a_nxt;
         r_b <= w_b_nxt;
      end
   end

   assign x_ready = !r_b.vld;
   assign m_valid = r_a.vld;
   assign m_read  = r_a.vld && r_a.rd;
   assign m_write = r_a.vld && r_a.wr;
   assign m_addr  = r_a.addr;
   assign m_val   = r_a.val;
   assign m_dst   = r_a.dst;

endmodule

// File: doc/xm_stage_buf.md
Name: xm_stage_buf

Overview:
- Parametrised EX→MEM boundary block. Selects the memory address and value from NSRC execute-side result sources (ALU, FPU, …).
- Adds write-back forwarding into store data, which the previous generation left disabled.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a memory stall does not combinationally back-propagate into execute.
- Sits between the execute units and the data-memory port.

Parameters:
- DATA_W, 32, width of a data value.
- ADDR_W, 32, width of a memory address.
- REG_W, 5, register-index width.
- NSRC, 2, number of execute result sources. Source 0 is the ALU, source 1 is the FPU.
- SEL_W, max(1,$clog2(NSRC)), selector width. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all buffered ops
- x_valid  in  1  execute presents an op
- x_ready  out  1  block accepts an op this cycle
- x_addr  in  NSRC*ADDR_W  packed per-source addresses, source i at [i*ADDR_W +: ADDR_W]
- x_val  in  NSRC*DATA_W  packed per-source values
- x_addr_sel  in  SEL_W  address source select
- x_val_sel  in  SEL_W  value source select
- x_read  in  1  load op
- x_write  in  1  store op
- x_dst  in  REG_W  destination register
- x_rt  in  REG_W  store-data source register
- wb_valid  in  1  write-back is writing a register
- wb_dst  in  REG_W  write-back register
- wb_val  in  DATA_W  write-back value
- m_valid  out  1  op presented to memory
- m_ready  in  1  memory accepts the op
- m_read, m_write  out  1  op type
- m_addr  out  ADDR_W  memory address
- m_val  out  DATA_W  store data or pass-through result
- m_dst  out  REG_W  destination register

Behaviour:
- Storage: entry A (head, drives the m_* outputs) and entry B (skid). Each entry holds valid, read, write, addr, val, dst, rt.
- Reset (rst_n=0, asynchronous):
  - A.valid=B.valid=0; all m_* outputs = 0.
  - x_ready=1 from the first edge after deassert.
- x_ready = !B.valid. This is a registered-state-only signal with no combinational path from m_ready.
- Select: addr = x_addr[x_addr_sel]; val = x_val[x_val_sel]. A select ≥ NSRC selects source 0.
- Capture forwarding: if x_write && wb_valid && wb_dst==x_rt && x_rt!=0, the captured val is wb_val instead of the selected source.
- Hold forwarding: every cycle, for each valid buffered entry with write=1 and rt==wb_dst (rt!=0, wb_valid=1), val is overwritten with wb_val on the next edge.
- Accept = x_valid && x_ready. Drain = A.valid && m_ready.
- Transitions per edge:
  - A empty, accept: load A.
  - A full, drain, no accept: A←B (B.valid may be 0); B cleared.
  - A full, drain, accept: if B.valid, A←B and B←new; else A←new.
  - A full, no drain, accept: B←new (x_ready drops next cycle).
  - No accept, no drain: hold.
- Ordering: strictly FIFO; the A→B→… order is never reordered.
- m_valid = A.valid. m_* fields show A's contents. When A.valid=0, m_read=m_write=0 (addr/val/dst don't-care, held).
- An op with neither read nor write passes through unchanged. m_val carries the selected result for write-back.
- Flush:
  - Synchronous; clears A.valid and B.valid on the next edge.
  - Overrides a same-cycle accept: the new op is dropped.
  - x_ready=1 in the following cycle.
  - A drain in the same cycle as flush still completes on the memory side; no duplicate is issued.
- Latency: 1 cycle from accept to m_valid when the buffer is empty. Throughput is 1 op/cycle while m_ready=1.
- Full: with A and B both valid and m_ready=0, x_ready=0 and state holds indefinitely.

Test Plan:
- Reset then single load, sel=0:
  - Stimulus: x_addr src0=0x100, x_read=1.
  - Response: next cycle m_valid=1, m_read=1, m_addr=0x100, m_dst=x_dst. Drops after m_ready=1.
- FPU select, NSRC=2:
  - Stimulus: x_addr_sel=1, x_val_sel=1, src1 addr=0x2000, val=0x3F800000.
  - Response: m_addr=0x2000, m_val=0x3F800000.
- Capture forwarding:
  - Stimulus: store with x_rt=7, src val=0x11; same cycle wb_valid=1, wb_dst=7, wb_val=0xAB.
  - Response: m_val=0xAB. Repeat with x_rt=0: m_val=0x11.
- Stall/skid:
  - Stimulus: m_ready=0, push ops 1,2,3.
  - Response: ops 1 and 2 accepted, x_ready=0 at op 3. While held, wb_dst=op2.rt with wb_val=0x55 sets op2 val to 0x55. Then m_ready=1 drains 1,2,3 in order, one per cycle.
- Flush:
  - Stimulus: A and B full, flush=1 with x_valid=1.
  - Response: next cycle m_valid=0, x_ready=1, and the dropped op never appears.
- Async reset mid-stall:
  - Stimulus: rst_n low between edges.
  - Response: m_valid=0 immediately; after release, a fresh op has 1-cycle latency.
